seq_control: RTL

SEQ_CONTROL -- requirements
Module: seq_control

---
 rtl/mano_pkg.sv | 32 +++
 rtl/dec3to8.sv | 13 +
 rtl/seq_control.sv | 108 ++++++++++
 3 files changed

// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control sequencer: opcode indices,
// timing-signal indices, instruction-register bit positions and run states.
package mano_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_STA   = 3'd3;
    localparam logic [2:0] OP_BUN   = 3'd4;
    localparam logic [2:0] OP_BSA   = 3'd5;
    localparam logic [2:0] OP_ISZ   = 3'd6;
    localparam logic [2:0] OP_IOREG = 3'd7;

    localparam int T0_IDX = 0;
    localparam int T1_IDX = 1;
    localparam int T2_IDX = 2;
    localparam int T3_IDX = 3;
    localparam int T4_IDX = 4;
    localparam int T5_IDX = 5;
    localparam int T6_IDX = 6;

    localparam int HLT_BIT = 0;
    localparam int IND_BIT = 15;
    localparam int OP_LSB  = 12;
    localparam int OP_MSB  = 14;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder used for both the timing signals and the opcode decode.
module dec3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign o_onehot[gi] = (i_sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/seq_control.sv
// Fetch/decode sequencer: sequence counter, IR, indirect bit and run flip-flop,
// with combinational control strobes decoded from that state.
module seq_control
    import mano_pkg::*;
#(
    parameter logic START_ON_RESET = 1'b1,
    parameter int   SC_W           = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [15:0]     IN,
    input  logic            START,
    output logic [SC_W-1:0] t,
    output logic [7:0]      T,
    output logic [7:0]      D,
    output logic            I,
    output logic [15:0]     IR_Q,
    output logic            RUN,
    output logic            LD_IR,
    output logic            INC_PC,
    output logic            LD_AR,
    output logic            INC_AR,
    output logic            CLR_SC
);

    logic [SC_W-1:0] r_sc;
    logic [15:0]     r_ir;
    logic            r_i;
    run_state_t      r_state;

    run_state_t      w_state_next;
    logic [SC_W-1:0] w_sc_next;
    logic            w_ld_i;
    logic            w_hlt;

    dec3to8 u_dec_t (
        .i_sel    (r_sc),
        .o_onehot (T)
    );

    dec3to8 u_dec_d (
        .i_sel    (r_ir[OP_MSB:OP_LSB]),
        .o_onehot (D)
    );

    assign w_hlt = D[OP_IOREG] & ~r_i & T[T3_IDX] & r_ir[HLT_BIT];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sc    <= '0;
            r_ir    <= '0;
            r_i     <= 1'b0;
            r_state <= START_ON_RESET ? ST_RUN : ST_HALT;
        end else begin
            r_sc    <= w_sc_next;
            r_state <= w_state_next;
            if (LD_IR) begin
                r_ir <= IN;
            end
            if (w_ld_i) begin
                r_i <= r_ir[IND_BIT];
            end
        end
    end

    // A halted machine parks SC at 0 so a START resumes cleanly at T0.
    always_comb begin
        w_state_next = r_state;
        w_sc_next    = '0;
        w_ld_i       = 1'b0;
        LD_IR        = 1'b0;
        INC_PC       = 1'b0;
        LD_AR        = 1'b0;
        INC_AR       = 1'b0;
        CLR_SC       = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (START) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                LD_IR  = T[T1_IDX];
                INC_PC = T[T1_IDX];
                LD_AR  = T[T0_IDX] | T[T2_IDX] | (~D[OP_IOREG] & r_i & T[T3_IDX]);
                INC_AR = D[OP_BSA] & T[T4_IDX];
                CLR_SC = (D[OP_IOREG] & T[T3_IDX])
                       | ((D[OP_AND] | D[OP_ADD] | D[OP_LDA] | D[OP_BSA]) & T[T5_IDX])
                       | ((D[OP_STA] | D[OP_BUN]) & T[T4_IDX])
                       | (D[OP_ISZ] & T[T6_IDX]);
                w_ld_i = T[T2_IDX];
                // HLT beats a concurrent START; SC wraps 7->0 by plain overflow.
                if (w_hlt) begin
                    w_state_next = ST_HALT;
                end else if (!CLR_SC) begin
                    w_sc_next = r_sc + SC_W'(1);
                end
            end
            default: w_state_next = ST_HALT;
        endcase
    end

    assign t    = r_sc;
    assign I    = r_i;
    assign IR_Q = r_ir;
    assign RUN  = (r_state == ST_RUN);

endmodule
